// File: rtl/mcb_cal_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mcb_cal_pkg
// Shared definitions for the MCB calibration start-up sequencer:
//   - seq_state_e : sequencer state encodings (also exported on seq_state)
//   - DEF_*       : default parameter values
//   - cnt_width() : counter width for a given terminal count
// ---------------------------------------------------------------------------
package mcb_cal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOCK_WAIT = 3'd1,
    ST_CAL_START = 3'd2,
    ST_CAL_WAIT  = 3'd3,
    ST_RUN       = 3'd4,
    ST_RETRY     = 3'd5,
    ST_FAIL      = 3'd6
  } seq_state_e;

  localparam int DEF_LOCK_STABLE_CYC = 64;
  localparam int DEF_CAL_TIMEOUT_CYC = 4096;
  localparam int DEF_MAX_RETRY       = 3;
  localparam int DEF_LOSS_FILTER_CYC = 16;

  // One spare bit above $clog2 so the terminal value itself always fits.
  function automatic int cnt_width(input int terminal);
    return $clog2(terminal) + 1;
  endfunction

endpackage

// File: rtl/mcb_cal_sequencer_sync2.sv
// ---------------------------------------------------------------------------
// mcb_sync2
// Two-flop synchronizer for a single-bit level into the mcb_drp_clk domain.
// Ports:
//   mcb_drp_clk : destination clock
//   sys_rst     : asynchronous active-high reset (flops clear to 0)
//   d_i         : asynchronous input level
//   q_o         : synchronized level, two cycles of latency
// ---------------------------------------------------------------------------
module mcb_sync2 (
  input  logic mcb_drp_clk,
  input  logic sys_rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge mcb_drp_clk or posedge sys_rst) begin
    if (sys_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mcb_cal_sequencer.sv
// ---------------------------------------------------------------------------
// mcb_cal_sequencer
// Calibration start-up sequencer for the MCB. Qualifies BUFPLL_MCB lock
// stability, pulses cal_start to the soft-calibration logic, supervises
// calib_done with a timeout and bounded retry, and reports ready/fail.
//
// Ports:
//   mcb_drp_clk : sequencer clock
//   sys_rst     : asynchronous active-high reset
//   pll_lock    : BUFPLL_MCB lock (asynchronous, synchronized here)
//   calib_done  : MCB calibration complete level (synchronized here)
//   cal_start   : one-cycle calibration request pulse
//   cal_ready   : calibration complete and sequencer in RUN
//   cal_fail    : sticky, all retries exhausted
//   lock_lost   : sticky, filtered lock loss seen while in RUN
//   retry_cnt   : attempts made after the first, saturates at MAX_RETRY
//   seq_state   : current state encoding (debug)
//
// Build option MCB_LOCK_RECAL_EN: when defined, a filtered lock loss in RUN
// drops cal_ready, clears retry_cnt and restarts from LOCK_WAIT. When not
// defined, RUN is held through lock loss and only lock_lost is raised.
// ---------------------------------------------------------------------------
module mcb_cal_sequencer
  import mcb_cal_pkg::*;
#(
  parameter int LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
  parameter int CAL_TIMEOUT_CYC = DEF_CAL_TIMEOUT_CYC,
  parameter int MAX_RETRY       = DEF_MAX_RETRY,
  parameter int LOSS_FILTER_CYC = DEF_LOSS_FILTER_CYC
) (
  input  logic       mcb_drp_clk,
  input  logic       sys_rst,
  input  logic       pll_lock,
  input  logic       calib_done,
  output logic       cal_start,
  output logic       cal_ready,
  output logic       cal_fail,
  output logic       lock_lost,
  output logic [3:0] retry_cnt,
  output logic [2:0] seq_state
);

  localparam int LOCK_W = cnt_width(LOCK_STABLE_CYC);
  localparam int TMO_W  = cnt_width(CAL_TIMEOUT_CYC);
  localparam int LOSS_W = cnt_width(LOSS_FILTER_CYC);

  localparam logic [LOCK_W-1:0] LOCK_TERM = LOCK_W'(LOCK_STABLE_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_TERM  = TMO_W'(CAL_TIMEOUT_CYC - 1);
  localparam logic [LOSS_W-1:0] LOSS_PRE  = LOSS_W'(LOSS_FILTER_CYC - 1);
  localparam logic [LOSS_W-1:0] LOSS_TERM = LOSS_W'(LOSS_FILTER_CYC);
  localparam logic [3:0]        RETRY_MAX = 4'(MAX_RETRY);

  logic lock_s;
  logic done_s;

  mcb_sync2 u_sync_lock (
    .mcb_drp_clk (mcb_drp_clk),
    .sys_rst     (sys_rst),
    .d_i         (pll_lock),
    .q_o         (lock_s)
  );

  mcb_sync2 u_sync_done (
    .mcb_drp_clk (mcb_drp_clk),
    .sys_rst     (sys_rst),
    .d_i         (calib_done),
    .q_o         (done_s)
  );

  seq_state_e        state_q;
  logic [LOCK_W-1:0] stab_cnt_q;
  logic [TMO_W-1:0]  tmo_cnt_q;
  logic [LOSS_W-1:0] loss_cnt_q;
  logic [3:0]        retry_q;
  logic              cal_start_q;
  logic              cal_ready_q;
  logic              cal_fail_q;
  logic              lock_lost_q;

  // Outputs are registered alongside the state so they line up exactly
  // with seq_state (cal_start is high for the single CAL_START cycle).
  always_ff @(posedge mcb_drp_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      stab_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      loss_cnt_q  <= '0;
      retry_q     <= '0;
      cal_start_q <= 1'b0;
      cal_ready_q <= 1'b0;
      cal_fail_q  <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      cal_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (lock_s) begin
            stab_cnt_q <= '0;
            state_q    <= ST_LOCK_WAIT;
          end
        end

        ST_LOCK_WAIT: begin
          if (!lock_s) begin
            stab_cnt_q <= '0;
            state_q    <= ST_IDLE;
          end else if (stab_cnt_q == LOCK_TERM) begin
            cal_start_q <= 1'b1;
            tmo_cnt_q   <= '0;
            state_q     <= ST_CAL_START;
          end else begin
            stab_cnt_q <= stab_cnt_q + 1'b1;
          end
        end

        ST_CAL_START: begin
          tmo_cnt_q <= '0;
          state_q   <= ST_CAL_WAIT;
        end

        ST_CAL_WAIT: begin
          // Completion wins over both timeout and lock abort.
          if (done_s) begin
            loss_cnt_q  <= '0;
            cal_ready_q <= 1'b1;
            state_q     <= ST_RUN;
          end else if (!lock_s || tmo_cnt_q == TMO_TERM) begin
            state_q <= ST_RETRY;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end

        ST_RETRY: begin
          if (retry_q < RETRY_MAX) begin
            retry_q    <= retry_q + 1'b1;
            stab_cnt_q <= '0;
            state_q    <= ST_LOCK_WAIT;
          end else begin
            cal_fail_q <= 1'b1;
            state_q    <= ST_FAIL;
          end
        end

        ST_RUN: begin
          // done_s is deliberately not looked at here: a falling calib_done
          // after calibration must not disturb a running interface.
          if (lock_s) begin
            loss_cnt_q <= '0;
          end else if (loss_cnt_q == LOSS_PRE) begin
            loss_cnt_q  <= LOSS_TERM;
            lock_lost_q <= 1'b1;
`ifdef MCB_LOCK_RECAL_EN
            cal_ready_q <= 1'b0;
            retry_q     <= '0;
            stab_cnt_q  <= '0;
            loss_cnt_q  <= '0;
            state_q     <= ST_LOCK_WAIT;
`endif
          end else if (loss_cnt_q != LOSS_TERM) begin
            loss_cnt_q <= loss_cnt_q + 1'b1;
          end
        end

        ST_FAIL: begin
          cal_ready_q <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cal_start = cal_start_q;
  assign cal_ready = cal_ready_q;
  assign cal_fail  = cal_fail_q;
  assign lock_lost = lock_lost_q;
  assign retry_cnt = retry_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_mcb_cal_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mcb_cal_sequencer
// Directed, table-driven bench for mcb_cal_sequencer. Each record holds the
// input levels, how many clock edges to hold them, and the outputs expected
// after the last edge (plus the running count of cal_start pulses).
// ---------------------------------------------------------------------------
module tb_mcb_cal_sequencer;

  localparam int LOCK_N = 64;
  localparam int TMO_N  = 32;
  localparam int RETRY  = 3;
  localparam int LOSS_N = 16;

`ifdef MCB_LOCK_RECAL_EN
  localparam bit RECAL = 1'b1;
`else
  localparam bit RECAL = 1'b0;
`endif

  localparam logic [2:0] S_IDLE = 3'd0, S_LW = 3'd1, S_CS = 3'd2, S_CW = 3'd3,
                         S_RUN = 3'd4, S_RT = 3'd5, S_FAIL = 3'd6;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       pll_lock = 1'b0;
  logic       calib_done = 1'b0;
  logic       cal_start, cal_ready, cal_fail, lock_lost;
  logic [3:0] retry_cnt;
  logic [2:0] seq_state;

  mcb_cal_sequencer #(
    .LOCK_STABLE_CYC (LOCK_N),
    .CAL_TIMEOUT_CYC (TMO_N),
    .MAX_RETRY       (RETRY),
    .LOSS_FILTER_CYC (LOSS_N)
  ) dut (
    .mcb_drp_clk (clk),
    .sys_rst     (sys_rst),
    .pll_lock    (pll_lock),
    .calib_done  (calib_done),
    .cal_start   (cal_start),
    .cal_ready   (cal_ready),
    .cal_fail    (cal_fail),
    .lock_lost   (lock_lost),
    .retry_cnt   (retry_cnt),
    .seq_state   (seq_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       lock;
    logic       done;
    int         n;
    logic [2:0] st;
    logic       start;
    logic       ready;
    logic       fail;
    logic       lost;
    logic [3:0] retry;
    int         pulses;
  } vec_t;

  vec_t vecs[$];
  int   vectors_applied = 0;
  int   miscompares = 0;
  int   pulses = 0;

  task automatic add(input logic rst, input logic lock, input logic done,
                     input int n, input logic [2:0] st, input logic start,
                     input logic ready, input logic fail, input logic lost,
                     input logic [3:0] retry, input int p);
    vec_t v;
    v.rst = rst; v.lock = lock; v.done = done; v.n = n; v.st = st;
    v.start = start; v.ready = ready; v.fail = fail; v.lost = lost;
    v.retry = retry; v.pulses = p;
    vecs.push_back(v);
  endtask

  task automatic chk(input int idx, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL vec %0d %s: got %0d expected %0d", idx, what, act, exp);
    end
  endtask

  task automatic apply(input int i);
    vec_t v;
    v = vecs[i];
    sys_rst    = v.rst;
    pll_lock   = v.lock;
    calib_done = v.done;
    if (v.rst) pulses = 0;
    repeat (v.n) begin
      @(posedge clk);
      #1;
      if (cal_start) pulses++;
    end
    chk(i, "seq_state", 32'(seq_state), 32'(v.st));
    chk(i, "cal_start", 32'(cal_start), 32'(v.start));
    chk(i, "cal_ready", 32'(cal_ready), 32'(v.ready));
    chk(i, "cal_fail",  32'(cal_fail),  32'(v.fail));
    chk(i, "lock_lost", 32'(lock_lost), 32'(v.lost));
    chk(i, "retry_cnt", 32'(retry_cnt), 32'(v.retry));
    chk(i, "pulses",    32'(pulses),    32'(v.pulses));
    vectors_applied++;
    $display("vec %0d rst=%0b lock=%0b done=%0b n=%0d -> st=%0d start=%0b rdy=%0b fail=%0b lost=%0b retry=%0d pulses=%0d",
             i, v.rst, v.lock, v.done, v.n, seq_state, cal_start, cal_ready,
             cal_fail, lock_lost, retry_cnt, pulses);
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) apply(i);
  endtask

  // Reset asserted mid-cycle: outputs must clear before any clock edge.
  task automatic async_rst_check(input int tag);
    #3;
    sys_rst = 1'b1;
    #1;
    chk(tag, "async seq_state", 32'(seq_state), 32'(S_IDLE));
    chk(tag, "async cal_start", 32'(cal_start), 32'd0);
    chk(tag, "async cal_ready", 32'(cal_ready), 32'd0);
    chk(tag, "async cal_fail",  32'(cal_fail),  32'd0);
    chk(tag, "async lock_lost", 32'(lock_lost), 32'd0);
    chk(tag, "async retry_cnt", 32'(retry_cnt), 32'd0);
    vectors_applied++;
    $display("async reset %0d -> st=%0d rdy=%0b fail=%0b lost=%0b retry=%0d",
             tag, seq_state, cal_ready, cal_fail, lock_lost, retry_cnt);
  endtask

  int a_end, b_end, c_end, d_mid;

  initial begin
    // A: nominal bring-up, done-fall ignored, loss filter boundary.
    add(1,0,0, 3, S_IDLE,0,0,0,0,0,0);
    add(0,0,0, 4, S_IDLE,0,0,0,0,0,0);
    add(0,1,0,66, S_LW,  0,0,0,0,0,0);
    add(0,1,0, 1, S_CS,  1,0,0,0,0,1);
    add(0,1,0, 1, S_CW,  0,0,0,0,0,1);
    add(0,1,1, 2, S_CW,  0,0,0,0,0,1);
    add(0,1,1, 1, S_RUN, 0,1,0,0,0,1);
    add(0,1,0,10, S_RUN, 0,1,0,0,0,1);
    add(0,0,0,15, S_RUN, 0,1,0,0,0,1);
    add(0,1,0, 5, S_RUN, 0,1,0,0,0,1);
    add(0,0,0,18, RECAL ? S_LW   : S_RUN, 0, !RECAL, 0,1,0,1);
    add(0,0,0, 1, RECAL ? S_IDLE : S_RUN, 0, !RECAL, 0,1,0,1);
    add(0,1,0,66, RECAL ? S_LW   : S_RUN, 0, !RECAL, 0,1,0,1);
    add(0,1,0, 1, RECAL ? S_CS   : S_RUN, RECAL, !RECAL, 0,1,0, RECAL ? 2 : 1);
    a_end = vecs.size();
    // B: lock glitch at stability count 40, then timeouts until FAIL.
    add(1,0,0, 2, S_IDLE,0,0,0,0,0,0);
    add(0,1,0, 2, S_IDLE,0,0,0,0,0,0);
    add(0,1,0,41, S_LW,  0,0,0,0,0,0);
    add(0,0,0, 1, S_LW,  0,0,0,0,0,0);
    add(0,1,0, 2, S_IDLE,0,0,0,0,0,0);
    add(0,1,0,64, S_LW,  0,0,0,0,0,0);
    add(0,1,0, 1, S_CS,  1,0,0,0,0,1);
    add(0,1,0, 1, S_CW,  0,0,0,0,0,1);
    add(0,1,0,32, S_RT,  0,0,0,0,0,1);
    add(0,1,0, 1, S_LW,  0,0,0,0,1,1);
    add(0,1,0,64, S_CS,  1,0,0,0,1,2);
    add(0,1,0,98, S_CS,  1,0,0,0,2,3);
    add(0,1,0,98, S_CS,  1,0,0,0,3,4);
    add(0,1,0,33, S_RT,  0,0,0,0,3,4);
    add(0,1,0, 1, S_FAIL,0,0,1,0,3,4);
    add(0,1,0,20, S_FAIL,0,0,1,0,3,4);
    b_end = vecs.size();
    // C: done_s lands on the timeout cycle -> RUN, no retry.
    add(1,0,0, 2, S_IDLE,0,0,0,0,0,0);
    add(0,1,0,67, S_CS,  1,0,0,0,0,1);
    add(0,1,0,30, S_CW,  0,0,0,0,0,1);
    add(0,1,1, 3, S_RUN, 0,1,0,0,0,1);
    add(0,1,1, 5, S_RUN, 0,1,0,0,0,1);
    c_end = vecs.size();
    // D: reset during CAL_WAIT, then clean restart.
    add(1,0,0, 2, S_IDLE,0,0,0,0,0,0);
    add(0,1,0,67, S_CS,  1,0,0,0,0,1);
    add(0,1,0, 5, S_CW,  0,0,0,0,0,1);
    d_mid = vecs.size();
    add(1,1,0, 2, S_IDLE,0,0,0,0,0,0);
    add(0,0,0, 3, S_IDLE,0,0,0,0,0,0);
    add(0,1,0,67, S_CS,  1,0,0,0,0,1);

    run_range(0, a_end);
    run_range(a_end, b_end);
    async_rst_check(1000);
    run_range(b_end, d_mid);
    async_rst_check(1001);
    run_range(d_mid, vecs.size());

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
